// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the 8-bit CPU control unit:
//   - bit positions of the 16-bit control word (HLT..FI)
//   - opcode enumeration (OP_NOP..OP_HLT)
//   - T-state type
//   - the two fetch-cycle control words, common to every instruction
//   - cbit(): one-hot mask for a control bit, so microcode reads as OR-ed names
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Control word bit positions
   localparam int unsigned CB_HLT = 15; // halt clock
   localparam int unsigned CB_MI  = 14; // memory address register in
   localparam int unsigned CB_RI  = 13; // RAM in
   localparam int unsigned CB_RO  = 12; // RAM out
   localparam int unsigned CB_IO  = 11; // instruction register out
   localparam int unsigned CB_II  = 10; // instruction register in
   localparam int unsigned CB_AI  = 9;  // A register in
   localparam int unsigned CB_AO  = 8;  // A register out
   localparam int unsigned CB_EO  = 7;  // ALU out
   localparam int unsigned CB_SU  = 6;  // ALU subtract
   localparam int unsigned CB_BI  = 5;  // B register in
   localparam int unsigned CB_OI  = 4;  // output register in
   localparam int unsigned CB_CE  = 3;  // program counter enable
   localparam int unsigned CB_CO  = 2;  // program counter out
   localparam int unsigned CB_J   = 1;  // jump (program counter load)
   localparam int unsigned CB_FI  = 0;  // flags register in

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_STA = 4'd4,
      OP_LDI = 4'd5,
      OP_JMP = 4'd6,
      OP_JC  = 4'd7,
      OP_JZ  = 4'd8,
      OP_OUT = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   typedef logic [2:0] tstate_t;

   // Fetch words: T0 = CO|MI, T1 = RO|II|CE
   localparam logic [15:0] CW_FETCH_ADDR  = 16'h4004;
   localparam logic [15:0] CW_FETCH_INSTR = 16'h1408;

   function automatic logic [15:0] cbit(input int unsigned idx);
      return 16'(1) << idx;
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// -----------------------------------------------------------------------------
// microcode_rom
// Purely combinational microcode table: control word and last-step flag for the
// current opcode / T-state / flags.
// Ports:
//   opcode    in  4   instruction register upper nibble
//   t_state   in  3   current step 0..4
//   flag_c    in  1   carry flag (JC)
//   flag_z    in  1   zero flag (JZ)
//   ctrl_word out 16  control word for this step
//   last_step out 1   this step is the final step of the instruction
// -----------------------------------------------------------------------------
module microcode_rom
   import cpu_pkg::*;
#(
   parameter bit          EARLY_END = 1'b1,
   parameter int unsigned NUM_STEPS = 5
) (
   input  logic [3:0]  opcode,
   input  tstate_t     t_state,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic [15:0] ctrl_word,
   output logic        last_step
);

   localparam tstate_t FINAL_STEP = tstate_t'(NUM_STEPS - 1);

   // Step on which the instruction ends when early termination is enabled.
   tstate_t end_step;

   always_comb begin
      ctrl_word = '0;
      end_step  = 3'd2;

      // Opcode-dependent length; the shortest instruction still ends at T2
      // because the opcode only becomes valid there.
      case (opcode)
         OP_LDA, OP_STA: end_step = 3'd3;
         OP_ADD, OP_SUB: end_step = 3'd4;
         default:        end_step = 3'd2;
      endcase

      case (t_state)
         3'd0: ctrl_word = CW_FETCH_ADDR;
         3'd1: ctrl_word = CW_FETCH_INSTR;
         3'd2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA:
                  ctrl_word = cbit(CB_IO) | cbit(CB_MI);
               OP_LDI: ctrl_word = cbit(CB_IO) | cbit(CB_AI);
               OP_JMP: ctrl_word = cbit(CB_IO) | cbit(CB_J);
               OP_JC:  ctrl_word = flag_c ? (cbit(CB_IO) | cbit(CB_J)) : '0;
               OP_JZ:  ctrl_word = flag_z ? (cbit(CB_IO) | cbit(CB_J)) : '0;
               OP_OUT: ctrl_word = cbit(CB_AO) | cbit(CB_OI);
               OP_HLT: ctrl_word = cbit(CB_HLT);
               default: ctrl_word = '0;
            endcase
         end
         3'd3: begin
            case (opcode)
               OP_LDA:         ctrl_word = cbit(CB_RO) | cbit(CB_AI);
               OP_ADD, OP_SUB: ctrl_word = cbit(CB_RO) | cbit(CB_BI);
               OP_STA:         ctrl_word = cbit(CB_RI) | cbit(CB_AO);
               default:        ctrl_word = '0;
            endcase
         end
         3'd4: begin
            case (opcode)
               OP_ADD:  ctrl_word = cbit(CB_EO) | cbit(CB_AI) | cbit(CB_FI);
               OP_SUB:  ctrl_word = cbit(CB_EO) | cbit(CB_SU) | cbit(CB_AI)
                                    | cbit(CB_FI);
               default: ctrl_word = '0;
            endcase
         end
         default: ctrl_word = '0;
      endcase
   end

   assign last_step = EARLY_END ? (t_state == end_step) : (t_state == FINAL_STEP);

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Microcode control unit: T-state counter advanced by step_en, halt latch and
// reset gating around the combinational microcode ROM.
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset (priority over step_en)
//   step_en   in  1   advance one T-state strobe
//   opcode    in  4   instruction register upper nibble
//   flag_c    in  1   carry flag
//   flag_z    in  1   zero flag
//   ctrl_word out 16  control word (0 while rst, 0x8000 while halted)
//   t_state   out 3   current step
//   halted    out 1   HLT has executed
//   instr_end out 1   current step is the instruction's last
// -----------------------------------------------------------------------------
module control_sequencer
   import cpu_pkg::*;
#(
   parameter bit          EARLY_END = 1'b1,
   parameter int unsigned NUM_STEPS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step_en,
   input  logic [3:0]  opcode,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic [15:0] ctrl_word,
   output logic [2:0]  t_state,
   output logic        halted,
   output logic        instr_end
);

   tstate_t     t_state_q, t_state_d;
   logic        halted_q, halted_d;
   logic [15:0] rom_word;
   logic        rom_last;

   microcode_rom #(
      .EARLY_END (EARLY_END),
      .NUM_STEPS (NUM_STEPS)
   ) u_rom (
      .opcode    (opcode),
      .t_state   (t_state_q),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl_word (rom_word),
      .last_step (rom_last)
   );

   always_comb begin
      t_state_d = t_state_q;
      halted_d  = halted_q;
      if (step_en && !halted_q) begin
         // HLT parks the counter at T2; it is checked before last_step so it
         // also halts when every instruction runs the full five steps.
         if (t_state_q == 3'd2 && opcode == OP_HLT) begin
            halted_d = 1'b1;
         end else if (rom_last) begin
            t_state_d = '0;
         end else begin
            t_state_d = t_state_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_state_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         t_state_q <= t_state_d;
         halted_q  <= halted_d;
      end
   end

   // rst gates the live outputs immediately so the datapath sees no enables
   // during the reset cycle itself.
   assign ctrl_word = rst      ? 16'h0000 :
                      halted_q ? cbit(CB_HLT) : rom_word;
   assign instr_end = !rst && !halted_q && rom_last;
   assign t_state   = t_state_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench: the driver applies inputs just after each rising edge and
// queues the expected outputs for that cycle; a monitor on the falling edge
// pops and compares. Two DUTs: EARLY_END=1 (sel=0) and EARLY_END=0 (sel=1).
// -----------------------------------------------------------------------------
module tb_control_sequencer;

   logic        clk;
   logic        rst;
   logic        step;
   logic        sel;
   logic [3:0]  opcode;
   logic        flag_c;
   logic        flag_z;

   logic        step_a, step_b;
   logic [15:0] ctrl_a, ctrl_b;
   logic [2:0]  t_a, t_b;
   logic        halted_a, halted_b;
   logic        iend_a, iend_b;

   assign step_a = step & ~sel;
   assign step_b = step & sel;

   control_sequencer #(.EARLY_END(1'b1), .NUM_STEPS(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .step_en   (step_a),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl_word (ctrl_a),
      .t_state   (t_a),
      .halted    (halted_a),
      .instr_end (iend_a)
   );

   control_sequencer #(.EARLY_END(1'b0), .NUM_STEPS(5)) dut_full (
      .clk       (clk),
      .rst       (rst),
      .step_en   (step_b),
      .opcode    (opcode),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .ctrl_word (ctrl_b),
      .t_state   (t_b),
      .halted    (halted_b),
      .instr_end (iend_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        sel;
      logic [15:0] ctrl;
      logic [2:0]  t;
      logic        h;
      logic        ie;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_total = 0;
   int    n_pass  = 0;

   task automatic chk(input string nm, input string fld, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, expv);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t        e;
         string       nm;
         logic [15:0] ac;
         logic [2:0]  at;
         logic        ah, ai;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         ac = e.sel ? ctrl_b   : ctrl_a;
         at = e.sel ? t_b      : t_a;
         ah = e.sel ? halted_b : halted_a;
         ai = e.sel ? iend_b   : iend_a;
         $display("[%0t] %s dut=%0d ctrl=%04h t=%0d halted=%0b end=%0b",
                  $time, nm, e.sel, ac, at, ah, ai);
         chk(nm, "ctrl_word", int'(ac), int'(e.ctrl));
         chk(nm, "t_state",   int'(at), int'(e.t));
         chk(nm, "halted",    int'(ah), int'(e.h));
         chk(nm, "instr_end", int'(ai), int'(e.ie));
      end
   end

   // One cycle: apply inputs, queue the outputs expected during this cycle.
   task automatic cyc(input logic r, input logic s, input logic [3:0] op,
                      input logic c, input logic z,
                      input logic [15:0] ec, input logic [2:0] et,
                      input logic eh, input logic eie, input string nm);
      @(posedge clk);
      #1;
      rst    = r;
      step   = s;
      opcode = op;
      flag_c = c;
      flag_z = z;
      exp_q.push_back('{sel, ec, et, eh, eie});
      name_q.push_back(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; step = 1'b1; sel = 1'b0;
      opcode = 4'd0; flag_c = 1'b0; flag_z = 1'b0;

      // Reset with step_en high, then release
      cyc(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, "rst_0");
      cyc(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, "rst_1");
      cyc(0, 0, 0, 0, 0, 16'h4004, 0, 0, 0, "rst_release");

      // ADD: five steps
      cyc(0, 1, 2, 0, 0, 16'h4004, 0, 0, 0, "add_t0");
      cyc(0, 1, 2, 0, 0, 16'h1408, 1, 0, 0, "add_t1");
      cyc(0, 1, 2, 0, 0, 16'h4800, 2, 0, 0, "add_t2");
      cyc(0, 1, 2, 0, 0, 16'h1020, 3, 0, 0, "add_t3");
      cyc(0, 1, 2, 0, 0, 16'h0281, 4, 0, 1, "add_t4");
      cyc(0, 0, 2, 0, 0, 16'h4004, 0, 0, 0, "add_next");

      // JC not taken (opcode during T0 is irrelevant), then taken
      cyc(0, 1, 15, 1, 1, 16'h4004, 0, 0, 0, "jc0_t0_opx");
      cyc(0, 1, 7, 0, 0, 16'h1408, 1, 0, 0, "jc0_t1");
      cyc(0, 1, 7, 0, 0, 16'h0000, 2, 0, 1, "jc0_t2");
      cyc(0, 0, 7, 0, 0, 16'h4004, 0, 0, 0, "jc0_next");
      cyc(0, 1, 7, 1, 0, 16'h4004, 0, 0, 0, "jc1_t0");
      cyc(0, 1, 7, 1, 0, 16'h1408, 1, 0, 0, "jc1_t1");
      cyc(0, 1, 7, 1, 0, 16'h0802, 2, 0, 1, "jc1_t2");

      // JZ: flag rises while waiting in T2
      cyc(0, 1, 8, 0, 0, 16'h4004, 0, 0, 0, "jz_t0");
      cyc(0, 1, 8, 0, 0, 16'h1408, 1, 0, 0, "jz_t1");
      cyc(0, 0, 8, 0, 0, 16'h0000, 2, 0, 1, "jz_t2_z0");
      cyc(0, 1, 8, 0, 1, 16'h0802, 2, 0, 1, "jz_t2_z1");
      cyc(0, 0, 8, 0, 1, 16'h4004, 0, 0, 0, "jz_next");

      // LDA with a long strobe gap at T3
      cyc(0, 1, 1, 0, 0, 16'h4004, 0, 0, 0, "lda_t0");
      cyc(0, 1, 1, 0, 0, 16'h1408, 1, 0, 0, "lda_t1");
      cyc(0, 1, 1, 0, 0, 16'h4800, 2, 0, 0, "lda_t2");
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 1, 0, 0, 16'h1200, 3, 0, 1, "lda_t3_gap");
      cyc(0, 1, 1, 0, 0, 16'h1200, 3, 0, 1, "lda_t3");
      cyc(0, 0, 1, 0, 0, 16'h4004, 0, 0, 0, "lda_next");

      // HLT, ignored strobes, reset exit
      cyc(0, 1, 15, 0, 0, 16'h4004, 0, 0, 0, "hlt_t0");
      cyc(0, 1, 15, 0, 0, 16'h1408, 1, 0, 0, "hlt_t1");
      cyc(0, 1, 15, 0, 0, 16'h8000, 2, 0, 1, "hlt_t2");
      for (int i = 0; i < 5; i++)
         cyc(0, 1, 2, 1, 1, 16'h8000, 2, 1, 0, "halted_strobe");
      cyc(1, 1, 15, 0, 0, 16'h0000, 2, 1, 0, "halted_rst");
      cyc(0, 0, 0, 0, 0, 16'h4004, 0, 0, 0, "halted_exit");

      // Full-length DUT: LDI padded to T4
      sel = 1'b1;
      cyc(0, 1, 5, 0, 0, 16'h4004, 0, 0, 0, "full_ldi_t0");
      cyc(0, 1, 5, 0, 0, 16'h1408, 1, 0, 0, "full_ldi_t1");
      cyc(0, 1, 5, 0, 0, 16'h0A00, 2, 0, 0, "full_ldi_t2");
      cyc(0, 1, 5, 0, 0, 16'h0000, 3, 0, 0, "full_ldi_t3");
      cyc(0, 1, 5, 0, 0, 16'h0000, 4, 0, 1, "full_ldi_t4");
      cyc(0, 0, 5, 0, 0, 16'h4004, 0, 0, 0, "full_ldi_next");

      // Full-length DUT: reset with a strobe at T3 of ADD
      cyc(0, 1, 2, 0, 0, 16'h4004, 0, 0, 0, "full_add_t0");
      cyc(0, 1, 2, 0, 0, 16'h1408, 1, 0, 0, "full_add_t1");
      cyc(0, 1, 2, 0, 0, 16'h4800, 2, 0, 0, "full_add_t2");
      cyc(1, 1, 2, 0, 0, 16'h0000, 3, 0, 0, "full_add_t3_rst");
      cyc(0, 0, 2, 0, 0, 16'h4004, 0, 0, 0, "full_add_after_rst");

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcode control unit for the 8-bit CPU. It steps through T-states on each CPU step strobe from the clock block. It decodes the instruction-register opcode and the ALU flags into the 16-bit control word that drives the bus, register, RAM, ALU and program-counter enables. It sits between the clock block and the datapath and owns instruction sequencing, conditional jumps and halt.

Parameters:
EARLY_END, 1, 1 = jump to T0 after an instruction's last used step; 0 = always run T0..T4
NUM_STEPS, 5, T-states per instruction when EARLY_END=0 (legal value 5 only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
step_en  input  1  single-cycle strobe; advance one T-state when high
opcode  input  4  instruction register upper nibble
flag_c  input  1  registered carry flag
flag_z  input  1  registered zero flag
ctrl_word  output  16  control signals, bit order below
t_state  output  3  current step, 0..4
halted  output  1  high once HLT has executed
instr_end  output  1  high while t_state is the last step of the current instruction

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. rst has priority over step_en.
- ctrl_word bits: HLT[15] MI[14] RI[13] RO[12] IO[11] II[10] AI[9] AO[8] EO[7] SU[6] BI[5] OI[4] CE[3] CO[2] J[1] FI[0].
- Reset values: t_state=0, halted=0. While rst is high, ctrl_word=0x0000 and instr_end=0 (combinationally gated).
- ctrl_word and instr_end are combinational from registered t_state/halted plus the live opcode and flags. Latency 0. The datapath samples them on the step_en cycle.
- States:
  - T0: fetch address.
  - T1: fetch instruction. The IR loads on the T1 strobe.
  - T2..T4: execute.
  - HALTED.
- State advances only on cycles with step_en=1. With step_en=0, all outputs hold, however long the gap.
- Microcode:
  - T0: 0x4004 (CO|MI)
  - T1: 0x1408 (RO|II|CE)
  - LDA(1): T2 0x4800, T3 0x1200
  - ADD(2): T2 0x4800, T3 0x1020, T4 0x0281
  - SUB(3): T2 0x4800, T3 0x1020, T4 0x02C1
  - STA(4): T2 0x4800, T3 0x2100
  - LDI(5): T2 0x0A00
  - JMP(6): T2 0x0802
  - JC(7): T2 0x0802 if flag_c, else 0x0000
  - JZ(8): T2 0x0802 if flag_z, else 0x0000
  - OUT(14): T2 0x0110
  - HLT(15): T2 0x8000
  - NOP(0) and undefined opcodes 9..13: 0x0000
  - Unlisted steps: 0x0000
- Instruction length with EARLY_END=1:
  - 3 steps (end at T2): NOP, LDI, JMP, JC, JZ, OUT, HLT, undefined.
  - 4 steps (end at T3): LDA, STA.
  - 5 steps (end at T4): ADD, SUB.
  - The minimum is 3 because the opcode is only valid from T2.
- Instruction length with EARLY_END=0: always ends at T4.
- On a step_en at a step where instr_end=1, the next state is T0. Otherwise t_state+1. No wrap beyond 4 is reachable.
- HLT: a step_en at T2 with opcode=15 moves to HALTED, not T0.
  - In HALTED: halted=1, ctrl_word=0x8000, t_state=2, instr_end=0.
  - step_en is ignored; only rst exits HALTED, to T0.
- Reset mid-instruction returns to T0 with halted=0. A partially executed instruction is abandoned.
- Opcode or flag changes during T0/T1 have no effect on ctrl_word. A flag change during T2 of JC/JZ is reflected immediately; the value present on the step_en cycle is the one acted on.

Decomposition:
- Shared package cpu_pkg:
  - control bit index constants (HLT..FI)
  - opcode enum (OP_NOP..OP_HLT)
  - t_state typedef, logic [2:0]
  - fetch word constants 0x4004 and 0x1408
- Sub-module microcode_rom: purely combinational. Inputs opcode, t_state, flag_c, flag_z, EARLY_END. Outputs ctrl_word and last_step.
- control_sequencer holds the step counter, the halt register and rst gating.

Test Plan:
1. Reset: rst=1 for 2 cycles with step_en=1 -> ctrl_word=0x0000, t_state=0, halted=0. After release, ctrl_word=0x4004.
2. ADD: opcode=2, 5 strobes -> ctrl_word 0x4004, 0x1408, 0x4800, 0x1020, 0x0281. instr_end high only at T4. Next strobe gives t_state=0.
3. JC: opcode=7, flag_c=0 -> T2 word 0x0000, instr_end=1, then T0. Repeat with flag_c=1 -> T2 word 0x0802.
4. Strobe gaps: at T3 of LDA, hold step_en=0 for 10 cycles -> t_state=3 and ctrl_word=0x1200 stable throughout. The next strobe gives T0.
5. Halt: opcode=15 -> T2 word 0x8000. After the strobe, halted=1. 5 further strobes leave ctrl_word=0x8000 unchanged. rst then gives T0, ctrl_word=0x4004, halted=0.
6. EARLY_END=0: LDI runs T0..T4 with T3/T4 words 0x0000, instr_end only at T4. Then assert rst and step_en together at T3 of ADD -> t_state=0 on the next cycle.
